// File: rtl/div_sched_pkg.sv
// Shared types and constants for the round-robin divider scheduler.
package div_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int CNT_W = 16;

  // Requester ID width, never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_share_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
  import div_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    win,
  output logic               any
);

  int idx;

  always_comb begin
    grant = '0;
    win   = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        win        = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/div_share_sched.sv
// One restoring divider shared round-robin among NUM_REQ requesters.
// Define DIVSCHED_STATS_EN to add saturating grant/divide-by-zero counters.
module div_share_sched
  import div_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic                     clk_100mhz,
  input  logic                     sys_rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_quot,
  output logic [WIDTH-1:0]         rsp_rem,
  output logic                     rsp_dbz,
  output logic                     busy
`ifdef DIVSCHED_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] grant_cnt,
  output logic [CNT_W-1:0]         dbz_cnt
`endif
);

  localparam int ID_W = id_w(NUM_REQ);
  localparam int IT_W = $clog2(WIDTH + 1);

  state_t state, state_nxt;

  logic [ID_W-1:0]    rr_ptr, id_q, win;
  logic [NUM_REQ-1:0] grant;
  logic               any, arb_en, accept, acc_dbz, last_iter, q_bit;
  logic [WIDTH-1:0]   acc_dvd, acc_dvs;
  logic [WIDTH-1:0]   n_q, d_q, r_q, n_nxt, r_nxt;
  logic [IT_W-1:0]    iter_q;
  logic [WIDTH:0]     trial, diff;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .win   (win),
    .any   (any)
  );

  assign arb_en    = (state == IDLE) || (state == RESP);
  assign req_ready = arb_en ? grant : '0;
  assign accept    = arb_en && any;
  assign acc_dvd   = req_dividend[int'(win)*WIDTH +: WIDTH];
  assign acc_dvs   = req_divisor[int'(win)*WIDTH +: WIDTH];
  assign acc_dbz   = (acc_dvs == '0);
  assign busy      = (state != IDLE);
  assign last_iter = (iter_q == IT_W'(WIDTH - 1));

  // Partial remainder keeps its top bit in the shift so large divisors stay exact.
  assign trial = {r_q, n_q[WIDTH-1]};
  assign diff  = trial - {1'b0, d_q};
  assign q_bit = ~diff[WIDTH];
  assign r_nxt = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign n_nxt = {n_q[WIDTH-2:0], q_bit};

  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: begin
        if (accept) state_nxt = acc_dbz ? RESP : DIVIDE;
        else        state_nxt = IDLE;
      end
      DIVIDE:     if (last_iter) state_nxt = RESP;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      rr_ptr    <= '0;
      id_q      <= '0;
      n_q       <= '0;
      d_q       <= '0;
      r_q       <= '0;
      iter_q    <= '0;
      rsp_valid <= '0;
      rsp_quot  <= '0;
      rsp_rem   <= '0;
      rsp_dbz   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (accept) begin
        rr_ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        id_q   <= win;
        n_q    <= acc_dvd;
        d_q    <= acc_dvs;
        r_q    <= '0;
        iter_q <= '0;
        if (acc_dbz) begin
          rsp_valid <= grant;
          rsp_quot  <= '1;
          rsp_rem   <= acc_dvd;
          rsp_dbz   <= 1'b1;
        end
      end else if (state == DIVIDE) begin
        n_q    <= n_nxt;
        r_q    <= r_nxt;
        iter_q <= iter_q + 1'b1;
        if (last_iter) begin
          rsp_valid <= NUM_REQ'(1) << id_q;
          rsp_quot  <= n_nxt;
          rsp_rem   <= r_nxt;
          rsp_dbz   <= 1'b0;
        end
      end
    end
  end

`ifdef DIVSCHED_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      grant_cnt <= '0;
      dbz_cnt   <= '0;
    end else if (accept) begin
      grant_cnt[int'(win)*CNT_W +: CNT_W] <= sat_inc(grant_cnt[int'(win)*CNT_W +: CNT_W]);
      if (acc_dbz) dbz_cnt <= sat_inc(dbz_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_div_share_sched.sv
// Scoreboard bench for div_share_sched: random and directed requests against a
// cycle-level arithmetic reference model.
module tb_div_share_sched;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk_100mhz = 1'b0;
  logic           sys_rst;
  logic [N-1:0]   req_valid, req_ready, rsp_valid;
  logic [N*W-1:0] req_dividend, req_divisor;
  logic [W-1:0]   rsp_quot, rsp_rem;
  logic           rsp_dbz, busy;
`ifdef DIVSCHED_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     dbz_cnt;
`endif

  always #5 clk_100mhz = ~clk_100mhz;

  div_share_sched #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk_100mhz   (clk_100mhz),
    .sys_rst      (sys_rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .rsp_valid    (rsp_valid),
    .rsp_quot     (rsp_quot),
    .rsp_rem      (rsp_rem),
    .rsp_dbz      (rsp_dbz),
    .busy         (busy)
`ifdef DIVSCHED_STATS_EN
    ,
    .grant_cnt    (grant_cnt),
    .dbz_cnt      (dbz_cnt)
`endif
  );

  typedef struct {
    int         id;
    logic [W-1:0] q;
    logic [W-1:0] r;
    bit         dbz;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   drv_to = 0;
  bit   done = 1'b0;

  int m_ptr = 0, m_next_free = 0, m_last_acc = 0, m_dbz = 0;
  int m_gcnt[N];
  bit prev_rst = 1'b1;

  always @(posedge clk_100mhz) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor and reference model
  always @(negedge clk_100mhz) begin : mon
    logic [N-1:0] exp_rdy;
    logic [W-1:0] a, b;
    int           win;
    exp_t         e;
    if (sys_rst) begin
      m_ptr       = 0;
      m_next_free = cyc;
      m_last_acc  = cyc;
      m_dbz       = 0;
      for (int i = 0; i < N; i++) m_gcnt[i] = 0;
      exp_q.delete();
      prev_rst = 1'b1;
    end else begin
      if (prev_rst) begin
        chk("reset_quot", rsp_quot, 0);
        chk("reset_rem", rsp_rem, 0);
        chk("reset_dbz", rsp_dbz, 0);
        prev_rst = 1'b0;
      end
      chk("busy", busy, (cyc > m_last_acc) && (cyc <= m_next_free));
`ifdef DIVSCHED_STATS_EN
      for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], m_gcnt[i]);
      chk("dbz_cnt", dbz_cnt, m_dbz);
`endif
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_valid", rsp_valid, N'(1) << e.id);
          chk("rsp_quot", rsp_quot, e.q);
          chk("rsp_rem", rsp_rem, e.r);
          chk("rsp_dbz", rsp_dbz, e.dbz);
          chk("rsp_cycle", cyc, e.due);
        end
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        chk("rsp_missing", 1, 0);
        void'(exp_q.pop_front());
      end
      exp_rdy = '0;
      win = -1;
      if (cyc >= m_next_free)
        for (int k = 0; k < N; k++)
          if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      if (win >= 0) begin
        a = req_dividend[win*W +: W];
        b = req_divisor[win*W +: W];
        e.id = win;
        if (b == 0) begin
          e.q = '1; e.r = a; e.dbz = 1'b1; e.due = cyc + 1;
          m_dbz++;
        end else begin
          e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.due = cyc + W + 1;
        end
        exp_q.push_back(e);
        m_gcnt[win]++;
        m_ptr       = (win + 1) % N;
        m_last_acc  = cyc;
        m_next_free = e.due;
      end
      if (done) begin
        chk("queue_empty", exp_q.size(), 0);
        chk("driver_timeouts", drv_to, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  // Stimulus
  function automatic logic [W-1:0] rnd_dvd();
    case ($urandom % 4)
      0:       return W'($urandom % 20);
      1:       return 32'hFFFF_FFFF - W'($urandom % 16);
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_dvs();
    case ($urandom % 6)
      0:       return '0;
      1:       return W'(1 + $urandom % 9);
      2:       return 32'h8000_0000 | W'($urandom);
      3:       return W'(1 + $urandom % 1000);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic step(output logic [N-1:0] acc);
    @(negedge clk_100mhz);
    acc = req_ready & req_valid & {N{~sys_rst}};
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic load(input int i);
    req_valid[i] = 1'b1;
    req_dividend[i*W +: W] = rnd_dvd();
    req_divisor[i*W +: W]  = rnd_dvs();
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [N-1:0] acc;
    int n = 0;
    req_valid[i] = 1'b1;
    req_dividend[i*W +: W] = a;
    req_divisor[i*W +: W]  = b;
    do begin
      step(acc);
      n++;
    end while (!acc[i] && n < 100);
    if (!acc[i]) drv_to++;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    logic [N-1:0] acc;
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      step(acc);
      n++;
    end
    if (n >= 200) drv_to++;
    step(acc);
  endtask

  task automatic burst(input logic [N-1:0] mask, input int total);
    logic [N-1:0] acc;
    int got = 0, n = 0;
    for (int i = 0; i < N; i++) if (mask[i]) load(i);
    while (got < total && n < 2000) begin
      step(acc);
      n++;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          got++;
          if (got + $countones(req_valid & ~acc) < total) load(i);
          else req_valid[i] = 1'b0;
        end
      end
    end
    if (got < total) drv_to++;
    req_valid = req_valid & ~mask;
  endtask

  initial begin : drv
    logic [N-1:0] acc;
    sys_rst      = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    repeat (3) step(acc);
    sys_rst = 1'b0;
    step(acc);

    issue(0, 100, 7);
    drain();
    issue(2, 32'hFFFF_FFFF, 1);
    drain();
    issue(2, 5, 9);
    drain();
    issue(1, 1234, 0);
    drain();
    issue(3, 0, 17);
    drain();

    burst(4'hF, 10);
    drain();

    issue(0, 32'h8000_1234, 3);
    repeat (9) step(acc);
    sys_rst = 1'b1;
    step(acc);
    sys_rst = 1'b0;
    step(acc);
    burst(4'b1001, 2);
    drain();

    issue(1, 77, 5);
    issue(1, 9, 0);
    drain();
    issue(1, 32'hDEAD_BEEF, 32'hDEAD_BEF0);
    drain();

    for (int t = 0; t < 3000; t++) begin
      sys_rst = (t == 1500);
      step(acc);
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          if ($urandom % 3 != 0) load(i);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i]) begin
          if ($urandom % 4 == 0) load(i);
        end else if ($urandom % 60 == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    sys_rst   = 1'b0;
    req_valid = '0;
    drain();
    done = 1'b1;
    step(acc);
  end

endmodule
